// File: rtl/display_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_driver_pkg
// Description : Shared display definitions for the two-digit scan driver.
//               Holds the scan FSM state encoding, the digit-enable and
//               blank-segment constants, and a small elaboration helper.
// Revision    : 1.0 - initial release
// ============================================================================
package display_scan_driver_pkg;

    // Scan states. A frame runs GAP_O -> ON_O -> GAP_T -> ON_T and then
    // wraps back to GAP_O.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GAP_O = 3'd1,
        ST_ON_O  = 3'd2,
        ST_GAP_T = 3'd3,
        ST_ON_T  = 3'd4
    } state_t;

    // One-hot digit enables: bit 0 drives the ones digit, bit 1 the tens digit.
    localparam logic [1:0] c_dig_none = 2'b00;
    localparam logic [1:0] c_dig_ones = 2'b01;
    localparam logic [1:0] c_dig_tens = 2'b10;

    // All segments off.
    localparam logic [6:0] c_seg_blank = 7'h00;

    // Larger of two integers, used to size the shared slot/gap counter.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : display_scan_driver_pkg
`default_nettype wire

// File: rtl/display_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_driver_if
// Description : Bus bundle between the segment-code source and the scan
//               driver.
//                 enable     - 1 = scanning allowed, 0 = force blank/idle
//                 load       - 1-cycle strobe capturing seg_tens/seg_ones
//                 seg_tens   - 7-bit segment code for the tens digit
//                 seg_ones   - 7-bit segment code for the ones digit
//                 seg        - shared 7-bit segment bus (driver output)
//                 dig_en     - one-hot digit enable, [0]=ones, [1]=tens
//                 frame_done - pulse on the last tens-digit cycle of a frame
//               master : the side that supplies codes and watches the bus
//               slave  : the scan driver
// Revision    : 1.0 - initial release
// ============================================================================
interface display_scan_driver_if;

    logic       enable;
    logic       load;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       frame_done;

    modport master (
        output enable,
        output load,
        output seg_tens,
        output seg_ones,
        input  seg,
        input  dig_en,
        input  frame_done
    );

    modport slave (
        input  enable,
        input  load,
        input  seg_tens,
        input  seg_ones,
        output seg,
        output dig_en,
        output frame_done
    );

endinterface : display_scan_driver_if
`default_nettype wire

// File: rtl/display_scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_timer
// Description : Loadable down-counter with a terminal-count flag. Loading
//               value N-1 yields a phase of exactly N cycles: o_tc is high
//               while the count sits at zero, and the count holds at zero
//               rather than wrapping.
//                 clk          - clock, rising edge
//                 rst_n        - synchronous active-low reset, clears count
//                 i_load       - load i_load_value this edge (wins over count)
//                 i_load_value - value to load
//                 o_count      - current count
//                 o_tc         - terminal count (count == 0)
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == '0);

endmodule : display_scan_timer
`default_nettype wire

// File: rtl/display_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_driver
// Description : Time-multiplexes two 7-segment codes onto one shared segment
//               bus with one-hot digit enables. Loads are double-buffered
//               (pending -> active at each frame boundary) so a frame never
//               shows a torn tens/ones pair, and a blank gap precedes every
//               digit slot to suppress ghosting.
//                 clk    - clock, rising edge
//                 rst_n  - synchronous active-low reset
//                 bus    - display_scan_driver_if slave modport
//                          (enable, load, seg_tens, seg_ones in;
//                           seg, dig_en, frame_done out, all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_driver
    import display_scan_driver_pkg::*;
#(
    parameter int SLOT_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    display_scan_driver_if.slave  bus
);

    localparam int c_cnt_w = $clog2(max2(SLOT_CYCLES, GAP_CYCLES) + 1);
    localparam logic [c_cnt_w-1:0] c_gap_load  = c_cnt_w'(GAP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_slot_load = c_cnt_w'(SLOT_CYCLES - 1);

    state_t               r_state;
    state_t               w_next_state;

    logic [6:0]           r_pend_tens;
    logic [6:0]           r_pend_ones;
    logic                 r_pend_valid;
    logic [6:0]           r_active_tens;
    logic [6:0]           r_active_ones;

    logic [6:0]           r_seg;
    logic [1:0]           r_dig_en;
    logic                 r_frame_done;

    logic                 w_tmr_load;
    logic [c_cnt_w-1:0]   w_tmr_value;
    logic [c_cnt_w-1:0]   w_cnt;
    logic                 w_tc;
    logic                 w_commit;
    logic                 w_last_slot;
    logic [6:0]           w_seg_next;
    logic [1:0]           w_dig_next;

    // ------------------------------------------------------------------
    // Phase timer, shared by gap and slot phases; restarted on each
    // state change.
    // ------------------------------------------------------------------
    display_scan_timer #(
        .WIDTH (c_cnt_w)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_tmr_load),
        .i_load_value (w_tmr_value),
        .o_count      (w_cnt),
        .o_tc         (w_tc)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and derived control
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_tmr_value  = '0;

        case (r_state)
            ST_IDLE:  if (bus.load || r_pend_valid) w_next_state = ST_GAP_O;
            ST_GAP_O: if (w_tc) w_next_state = ST_ON_O;
            ST_ON_O:  if (w_tc) w_next_state = ST_GAP_T;
            ST_GAP_T: if (w_tc) w_next_state = ST_ON_T;
            ST_ON_T:  if (w_tc) w_next_state = ST_GAP_O;
            default:  w_next_state = ST_IDLE;
        endcase

        // Dropping enable aborts from anywhere, including the IDLE exit.
        if (!bus.enable) begin
            w_next_state = ST_IDLE;
        end

        w_tmr_load = (w_next_state != r_state);

        case (w_next_state)
            ST_GAP_O, ST_GAP_T: w_tmr_value = c_gap_load;
            ST_ON_O,  ST_ON_T:  w_tmr_value = c_slot_load;
            default:            w_tmr_value = '0;
        endcase

        // Frame boundary: the pending pair becomes active on entry to GAP_O.
        w_commit = (w_next_state == ST_GAP_O) && (r_state != ST_GAP_O);

        // The registered outputs describe the cycle that follows this edge,
        // so "last ON_T cycle" is judged on the post-edge count: either we
        // stay in ON_T and the count is about to hit zero, or we are just
        // entering a single-cycle ON_T slot.
        if (r_state == ST_ON_T) begin
            w_last_slot = (w_next_state == ST_ON_T) && (w_cnt == c_cnt_w'(1));
        end else begin
            w_last_slot = (w_next_state == ST_ON_T) && (SLOT_CYCLES == 1);
        end

        // Active registers only move at the GAP_O entry, where the bus is
        // blank, so the current active values are safe to use here.
        case (w_next_state)
            ST_ON_O: begin
                w_seg_next = r_active_ones;
                w_dig_next = c_dig_ones;
            end
            ST_ON_T: begin
                w_seg_next = r_active_tens;
                w_dig_next = c_dig_tens;
            end
            default: begin
                w_seg_next = c_seg_blank;
                w_dig_next = c_dig_none;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pending / active buffers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_tens   <= '0;
            r_pend_ones   <= '0;
            r_pend_valid  <= 1'b0;
            r_active_tens <= '0;
            r_active_ones <= '0;
        end else begin
            if (bus.load) begin
                r_pend_tens  <= bus.seg_tens;
                r_pend_ones  <= bus.seg_ones;
                r_pend_valid <= 1'b1;
            end
            if (w_commit) begin
                // A load on the commit edge bypasses pending so it is not
                // delayed by a whole frame.
                r_active_tens <= bus.load ? bus.seg_tens : r_pend_tens;
                r_active_ones <= bus.load ? bus.seg_ones : r_pend_ones;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg        <= c_seg_blank;
            r_dig_en     <= c_dig_none;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg_next;
            r_dig_en     <= w_dig_next;
            r_frame_done <= w_last_slot;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dig_en     = r_dig_en;
    assign bus.frame_done = r_frame_done;

endmodule : display_scan_driver
`default_nettype wire

// File: tb/tb_display_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_driver
// Description : Directed self-checking bench for display_scan_driver with
//               SLOT_CYCLES=4, GAP_CYCLES=1 (10-cycle frames). Expected
//               values are hand-derived constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_driver;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    display_scan_driver_if bus ();

    display_scan_driver #(
        .SLOT_CYCLES (4),
        .GAP_CYCLES  (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] e_seg,
                       input logic [1:0] e_dig, input logic e_fd);
        n_cmp++;
        assert (bus.seg === e_seg) else begin
            n_bad++;
            $error("FAIL %s seg: observed %02h expected %02h", tag, bus.seg, e_seg);
        end
        n_cmp++;
        assert (bus.dig_en === e_dig) else begin
            n_bad++;
            $error("FAIL %s dig_en: observed %b expected %b", tag, bus.dig_en, e_dig);
        end
        n_cmp++;
        assert (bus.frame_done === e_fd) else begin
            n_bad++;
            $error("FAIL %s frame_done: observed %b expected %b", tag, bus.frame_done, e_fd);
        end
    endtask

    task automatic blank(input string tag);
        chk(tag, 7'h00, 2'b00, 1'b0);
    endtask

    // Checks the nine cycles after GAP_O: ON_O x4, GAP_T, ON_T x4 (the last
    // with frame_done). Optionally pulses load during the first ON_O cycle.
    task automatic run_frame(input string tag, input logic [6:0] e_ones,
                             input logic [6:0] e_tens, input bit mid_load,
                             input logic [6:0] l_tens, input logic [6:0] l_ones);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("%s_on_o%0d", tag, i), e_ones, 2'b01, 1'b0);
            if (mid_load && i == 0) begin
                bus.load     = 1'b1;
                bus.seg_tens = l_tens;
                bus.seg_ones = l_ones;
            end else begin
                bus.load = 1'b0;
            end
        end
        tick();
        blank($sformatf("%s_gap_t", tag));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("%s_on_t%0d", tag, i), e_tens, 2'b10, (i == 3));
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.enable   = 1'b0;
        bus.load     = 1'b0;
        bus.seg_tens = 7'h00;
        bus.seg_ones = 7'h00;

        // Reset, then idle with enable high and nothing loaded.
        tick();
        tick();
        blank("reset");
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            blank($sformatf("idle%0d", i));
        end

        // First frame: load sampled at edge 1 -> GAP_O, ON_O at edges 2-5.
        bus.load     = 1'b1;
        bus.seg_tens = 7'h06;
        bus.seg_ones = 7'h4F;
        tick();
        bus.load = 1'b0;
        blank("f1_gap_o");
        run_frame("f1", 7'h4F, 7'h06, 1'b0, 7'h00, 7'h00);

        // Second frame re-commits the same pair; reload during ON_O must
        // not disturb it.
        tick();
        blank("f2_gap_o");
        run_frame("f2", 7'h4F, 7'h06, 1'b1, 7'h5B, 7'h66);

        // Third frame shows the mid-frame reload.
        tick();
        blank("f3_gap_o");
        run_frame("f3", 7'h66, 7'h5B, 1'b0, 7'h00, 7'h00);

        // Load coincident with the GAP_O entry bypasses pending.
        bus.load     = 1'b1;
        bus.seg_tens = 7'h3F;
        bus.seg_ones = 7'h7F;
        tick();
        bus.load = 1'b0;
        blank("f4_gap_o");
        run_frame("f4", 7'h7F, 7'h3F, 1'b0, 7'h00, 7'h00);

        // Enable drop in ON_T cycle 2: blank, no frame_done.
        tick();
        blank("f5_gap_o");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("f5_on_o%0d", i), 7'h7F, 2'b01, 1'b0);
        end
        tick();
        blank("f5_gap_t");
        tick();
        chk("f5_on_t0", 7'h3F, 2'b10, 1'b0);
        tick();
        chk("f5_on_t1", 7'h3F, 2'b10, 1'b0);
        bus.enable = 1'b0;
        tick();
        blank("drop0");
        tick();
        blank("drop1");
        bus.enable = 1'b1;
        tick();
        blank("reen_gap_o");
        run_frame("reen", 7'h7F, 7'h3F, 1'b0, 7'h00, 7'h00);

        // Load while disabled is still captured and shown after re-enable.
        bus.enable   = 1'b0;
        bus.load     = 1'b1;
        bus.seg_tens = 7'h6D;
        bus.seg_ones = 7'h07;
        tick();
        bus.load = 1'b0;
        blank("dis_load0");
        tick();
        blank("dis_load1");
        bus.enable = 1'b1;
        tick();
        blank("dl_gap_o");
        run_frame("dl", 7'h07, 7'h6D, 1'b0, 7'h00, 7'h00);

        // Reset during ON_O, then no load: stays idle.
        tick();
        blank("r_gap_o");
        tick();
        chk("r_on_o0", 7'h07, 2'b01, 1'b0);
        rst_n = 1'b0;
        tick();
        blank("r_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            blank($sformatf("r_idle%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_display_scan_driver
`default_nettype wire

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
- Downstream consumer of the two-digit binary-to-seven-segment display stage.
- Takes the per-digit segment codes (seg_tens, seg_ones) and time-multiplexes them onto one shared 7-bit segment bus with one-hot digit enables, for boards whose two digits share segment lines.
- Double-buffers each load so a frame never shows a torn tens/ones pair.
- Inserts a blanking gap between digits to prevent ghosting.

Parameters:
- SLOT_CYCLES, 4, cycles a digit is driven per slot (>=1)
- GAP_CYCLES, 1, blank cycles before each slot (>=1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  1 = scanning allowed; 0 = force blank/idle
- load  in  1  1-cycle strobe: capture seg_tens/seg_ones this edge
- seg_tens  in  7  segment code for tens digit (from display stage)
- seg_ones  in  7  segment code for ones digit (from display stage)
- seg  out  7  shared segment bus, registered
- dig_en  out  2  one-hot digit enable, registered; [0] = ones, [1] = tens
- frame_done  out  1  1-cycle pulse on the last ON_T cycle of a frame

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; seg=0; dig_en=00; frame_done=0; pend_valid=0; pending and active registers=0; counter=0. Reset mid-frame aborts immediately; nothing is committed.
- Load path:
  - On an edge with load=1, pend_tens/pend_ones <= inputs and pend_valid <= 1.
  - A later load overwrites pending (last write wins).
  - load while enable=0 is still captured.
- States: IDLE, GAP_O, ON_O, GAP_T, ON_T.
  - IDLE: seg=0, dig_en=00. Goes to GAP_O when enable=1 and (pend_valid=1 or load=1).
  - GAP_O / GAP_T: seg=0, dig_en=00 for GAP_CYCLES cycles.
  - ON_O: seg=active_ones, dig_en=01 for SLOT_CYCLES cycles.
  - ON_T: seg=active_tens, dig_en=10 for SLOT_CYCLES cycles, then back to GAP_O.
  - Frame length = 2*(GAP_CYCLES+SLOT_CYCLES) cycles.
- Commit: on every edge entering GAP_O, active <= pending.
  - If load=1 on that same edge, active <= seg_* inputs directly (bypass); pending also updates.
  - Active never changes outside frame boundaries.
- Latency from IDLE:
  - Load at edge t, enable=1: GAP_O registered at edge t+1.
  - First dig_en=01 at edge t+1+GAP_CYCLES.
  - A load mid-frame takes effect at the next GAP_O.
- enable=0 in any state: the next edge goes to IDLE and blanks outputs. Pending is retained. Re-enable restarts at GAP_O with a commit.
- Slot counter:
  - Width = $clog2(max(SLOT_CYCLES, GAP_CYCLES)+1).
  - Clears on every state change.
  - Terminal count is value-1; never wraps past it.
- frame_done=1 exactly on the final ON_T cycle. It is 0 if the frame is aborted by enable=0 or reset.
- dig_en is never 11. seg is 0 whenever dig_en=00.

Decomposition:
- Shared display package holds:
  - state enum (IDLE, GAP_O, ON_O, GAP_T, ON_T)
  - digit-enable constants DIG_NONE=00, DIG_ONES=01, DIG_TENS=10
  - SEG_BLANK=7'h00
- One natural sub-module: display_scan_timer, a loadable down-counter with a terminal-count flag, reused for both gap and slot timing.
- FSM, buffering and output registers stay in the top.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n=0 for 2 cycles, release, enable=1, no load for 10 cycles.
  - Required: seg=0, dig_en=00, frame_done=0 throughout.
- First frame:
  - Stimulus: SLOT=4, GAP=1, load tens=7'h06, ones=7'h4F at edge 0, enable=1.
  - Required: edge1 GAP_O (00); edges 2-5 dig_en=01, seg=4F; edge6 00; edges 7-10 dig_en=10, seg=06; frame_done at edge10; edge11 GAP_O.
- Mid-frame reload:
  - Stimulus: during ON_O, load tens=7'h5B, ones=7'h66.
  - Required: the current frame finishes showing 4F/06; the next frame shows 66/5B.
- Simultaneous load at commit:
  - Stimulus: load=1 on the edge entering GAP_O with tens=7'h3F, ones=7'h7F.
  - Required: the following ON_O shows 7F (bypass), not the old pending value.
- enable drop:
  - Stimulus: enable=0 in ON_T cycle 2.
  - Required: next edge dig_en=00, seg=0, no frame_done. enable=1 again: GAP_O, then the same pending values are shown.
- Reset mid-operation:
  - Stimulus: rst_n=0 in ON_O.
  - Required: next edge outputs 0. After release without a load, the driver stays in IDLE because pend_valid was cleared.
